fetch_controller: RTL
=====================

# fetch_controller

Instruction-fetch sequencer that owns the program counter and drives the address port of the synchronous-read instruction memory (one-cycle read latency, 16-bit words, 32 entries). It issues at most one fetch per cycle and buffers returning words in a 2-entry queue. It presents them to decode with a valid/ready handshake and honours branch redirects and halt/run control from the execute stage.

## Interface
Parameters:
- ADDR_WIDTH, 16, width of PC and memory address
- INSTR_WIDTH, 16, instruction word width
- MEM_DEPTH, 32, number of valid instruction words; legal PCs are 0..MEM_DEPTH-1
- RESET_PC, 0, PC loaded at reset

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- run  in  1  start/resume fetching
- halt  in  1  stop issuing new fetches
- redirect_valid  in  1  branch taken; load redirect_pc, flush
- redirect_pc  in  ADDR_WIDTH  absolute word address of branch target
- mem_addr  out  ADDR_WIDTH  to instruction memory address; equals PC register
- mem_instr  in  INSTR_WIDTH  instruction memory read data
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode accepts head
- instr_out  out  INSTR_WIDTH  queue head instruction
- instr_pc  out  ADDR_WIDTH  word address of instr_out
- fetch_fault  out  1  sticky; redirect target out of range
- busy  out  1  state is FETCH or a read is in flight

## Operation
- States: IDLE (reset), FETCH, HALT.
- Transitions: IDLE→FETCH on run; FETCH→HALT on halt; HALT→FETCH on run with fetch_fault=0; any state→HALT on a faulting redirect.
- Priority in a single cycle: reset > redirect > halt > run.
- Issue condition: state==FETCH and (count + inflight + 1) <= 2 + pop. Here count is queue occupancy 0..2, inflight is the issue flag registered last cycle, and pop = instr_valid & instr_ready.
- On issue:
  - PC <= PC+1; PC wraps from MEM_DEPTH-1 to 0.
  - inflight <= 1; the tag register <= PC.
- The memory reads every cycle; returning data is pushed into the queue only when inflight=1. The push carries the tag as instr_pc.
- Queue: 2-entry FIFO. Head drives instr_out/instr_pc. instr_valid = (count!=0). Simultaneous push and pop is allowed at any count.
- Redirect with redirect_pc < MEM_DEPTH:
  - Flush the queue, including an element popped the same cycle, which still counts as accepted.
  - Clear inflight, so the returning word is discarded.
  - PC <= redirect_pc. State is unchanged, except that redirect from IDLE or HALT only loads the PC.
- Redirect with redirect_pc >= MEM_DEPTH: flush as above, PC unchanged, fetch_fault <= 1, state <= HALT. fetch_fault clears only on reset.
- Halt:
  - No further issues.
  - A read already in flight is still captured.
  - The queue keeps draining to decode.
- Reset mid-operation: queue emptied, inflight cleared, and everything returns to reset values immediately (asynchronous).

## Timing
- Reset values: mem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, fetch_fault=0, busy=0, state IDLE, count 0.
- run sampled high in cycle t (IDLE) → FETCH in t+1, first issue in t+1, instr_valid=1 in t+3.
- Issue-to-valid latency: 2 cycles (issue at t, data at t+1, visible at queue head at t+2).
- Sustained throughput: 1 instruction/cycle while instr_ready=1.
- Redirect in cycle t → mem_addr=target in t+1; instr_valid=0 in t+1 and t+2; target valid in t+3.
- Backpressure: instr_ready low → issues stop once count+inflight reaches 2. No word is ever dropped or duplicated.

## Test plan
- Straight-line fetch: reset, run=1 and instr_ready=1 held → instr_pc 0,1,2,… on consecutive cycles from cycle 3. PC wraps 31→0 and instr_out matches memory contents.
- Backpressure: instr_ready low for 5 cycles mid-stream → count saturates at 2 and mem_addr stops advancing. On release, the sequence resumes with no gap or repeat in instr_pc.
- Redirect: while streaming, redirect_valid with redirect_pc=10 in cycle t → no valid in t+1 and t+2, instr_pc=10 in t+3, then 11, 12. Redirect on the same cycle as a pop → the popped word counts as accepted once.
- Faulting redirect: redirect_pc=40 → fetch_fault=1, state HALT, queue empty. A subsequent run stays halted until reset.
- Halt/resume: halt with one read in flight → that word is still delivered and no further issues occur. run → fetching resumes at the next sequential PC.
- Asynchronous reset asserted mid-stream, between clock edges → instr_valid=0 and mem_addr=RESET_PC immediately. After release, fetching waits for run.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues one read per cycle to a
// one-cycle-latency instruction memory and queues returned words for decode.
module fetch_controller #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned MEM_DEPTH   = 32,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   halt,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [INSTR_WIDTH-1:0] mem_instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   fetch_fault,
    output logic                   busy
);
    localparam int unsigned CNT_W = 2;
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PC    = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] tag;
    logic [ADDR_WIDTH-1:0] tag_next;
    logic                  inflight;
    logic                  inflight_next;
    entry_t                q_head;
    entry_t                q_head_next;
    entry_t                q_tail;
    entry_t                q_tail_next;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic                  fault_next;
    logic                  valid_next;
    logic                  busy_next;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic                  redirect_ok;
    logic                  redirect_bad;
    logic [OCC_W-1:0]      occupancy;
    logic [OCC_W-1:0]      capacity;
    entry_t                incoming;

    assign mem_addr  = pc;
    assign instr_out = q_head.instr;
    assign instr_pc  = q_head.pc;

    // State register and all datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_ADDR;
            tag         <= '0;
            inflight    <= 1'b0;
            q_head      <= '0;
            q_tail      <= '0;
            count       <= '0;
            fetch_fault <= 1'b0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            tag         <= tag_next;
            inflight    <= inflight_next;
            q_head      <= q_head_next;
            q_tail      <= q_tail_next;
            count       <= count_next;
            fetch_fault <= fault_next;
            instr_valid <= valid_next;
            busy        <= busy_next;
        end
    end

    // Next-state, issue and queue update
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        tag_next      = tag;
        inflight_next = 1'b0;
        q_head_next   = q_head;
        q_tail_next   = q_tail;
        count_next    = count;
        fault_next    = fetch_fault;
        valid_next    = 1'b0;
        busy_next     = 1'b0;

        pop            = instr_valid & instr_ready;
        redirect_ok    = redirect_valid && (redirect_pc <= LAST_PC);
        redirect_bad   = redirect_valid && (redirect_pc > LAST_PC);
        push           = inflight && !redirect_valid;
        incoming.pc    = tag;
        incoming.instr = mem_instr;

        // Slots already claimed plus the new one must fit in the space left after a pop
        occupancy = OCC_W'(count) + OCC_W'(inflight) + OCC_W'(1);
        capacity  = OCC_W'(2) + OCC_W'(pop);
        issue     = (state == ST_FETCH) && !redirect_valid && !halt && (occupancy <= capacity);

        if (redirect_bad) begin
            state_next = ST_HALT;
            fault_next = 1'b1;
        end else if (!redirect_ok) begin
            case (state)
                ST_IDLE:  if (run && !halt) state_next = ST_FETCH;
                ST_FETCH: if (halt) state_next = ST_HALT;
                ST_HALT:  if (run && !halt && !fetch_fault) state_next = ST_FETCH;
                default:  state_next = ST_IDLE;
            endcase
        end

        if (redirect_ok) begin
            pc_next = redirect_pc;
        end else if (issue) begin
            pc_next       = (pc == LAST_PC) ? '0 : pc + ADDR_WIDTH'(1);
            tag_next      = pc;
            inflight_next = 1'b1;
        end

        // A redirect flushes everything, including the word returning this cycle
        if (redirect_valid) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == CNT_W'(0)) begin
                        q_head_next = incoming;
                    end else if (count == CNT_W'(1)) begin
                        q_tail_next = incoming;
                    end
                    if (count != CNT_W'(2)) begin
                        count_next = count + CNT_W'(1);
                    end
                end
                2'b01: begin
                    q_head_next = q_tail;
                    count_next  = count - CNT_W'(1);
                end
                2'b11: begin
                    if (count == CNT_W'(2)) begin
                        q_head_next = q_tail;
                        q_tail_next = incoming;
                    end else begin
                        q_head_next = incoming;
                    end
                end
                default: ;
            endcase
        end

        valid_next = (count_next != '0);
        busy_next  = (state_next == ST_FETCH) || inflight_next;
    end

endmodule
